// File: rtl/seq_game_ctrl.sv
// ---------------------------------------------------------------------------
// seq_game_ctrl
// Memory-sequence game controller. Each round appends one symbol to a stored
// sequence, replays the whole sequence on the display (one symbol per 1 s
// tick), then checks the player's entries against it. The controller scores a
// correct round with +1 point and a wrong entry or timeout with -1 point. Both
// updates saturate.
//
// Ports
//   Clk        : clock, rising edge
//   Rst        : synchronous reset, active low
//   start_in   : game button, level-sampled in IDLE only
//   rand_in    : random symbol source used when a symbol is appended
//   tick_1s    : one-cycle pulse from the 1 s timer
//   p_valid    : one-cycle player-entry strobe
//   p_sym      : player symbol, qualified by p_valid
//   timer_en   : enables the external 1 s timer (SHOW / WAIT_IN)
//   disp_sym   : MSB=1 -> blank, else low bits are the displayed symbol
//   points     : saturating score
//   seq_len    : current sequence length (level)
//   entry_idx  : symbols shown or matched so far in the round
//   round_pass : one-cycle pulse on a correct round
//   round_fail : one-cycle pulse on a wrong entry or timeout
// ---------------------------------------------------------------------------
module seq_game_ctrl #(
  parameter int SYM_W   = 4,
  parameter int MAX_LEN = 16,
  parameter int PTS_W   = 5,
  parameter int TIMEOUT = 10,
  parameter int STRICT  = 1
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         start_in,
  input  logic [SYM_W-1:0]             rand_in,
  input  logic                         tick_1s,
  input  logic                         p_valid,
  input  logic [SYM_W-1:0]             p_sym,
  output logic                         timer_en,
  output logic [SYM_W:0]               disp_sym,
  output logic [PTS_W-1:0]             points,
  output logic [$clog2(MAX_LEN+1)-1:0] seq_len,
  output logic [$clog2(MAX_LEN+1)-1:0] entry_idx,
  output logic                         round_pass,
  output logic                         round_fail
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [SYM_W:0]   BLANK   = {1'b1, {SYM_W{1'b0}}};
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [PTS_W-1:0] PTS_MAX = '1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPEND,
    S_SHOW,
    S_WAIT_IN,
    S_PASS,
    S_FAIL
  } state_t;

  state_t           state_reg;
  logic [TO_W-1:0]  to_cnt_reg;
  logic [SYM_W-1:0] seq_mem [MAX_LEN];

  logic [SYM_W-1:0] base_sym;
  logic [SYM_W-1:0] bumped_sym;
  logic [SYM_W-1:0] last_sym;
  logic [SYM_W-1:0] cand_sym;
  logic [SYM_W-1:0] cur_sym;
  logic             wait_miss;

  // Candidate symbol: 0 is never stored, and a symbol never repeats its
  // predecessor, so every displayed symbol is visibly a new one.
  always_comb begin
    base_sym   = (rand_in == '0) ? SYM_W'(1) : rand_in;
    bumped_sym = base_sym + SYM_W'(1);
    if (bumped_sym == '0) begin
      bumped_sym = SYM_W'(1);
    end
    // Out-of-range read when seq_len==0 is harmless: the compare is gated.
    last_sym = seq_mem[IDX_W'(seq_len - LEN_W'(1))];
    cand_sym = base_sym;
    if ((seq_len != '0) && (base_sym == last_sym)) begin
      cand_sym = bumped_sym;
    end
    cur_sym = seq_mem[IDX_W'(entry_idx)];
    // A wrong entry, or the TIMEOUT-th tick with no entry in the same cycle
    // (an entry on the same cycle as a tick swallows the tick).
    wait_miss = (p_valid && (p_sym != cur_sym)) ||
                (!p_valid && tick_1s && (to_cnt_reg == TO_LAST));
  end

  // Sequence storage; contents are meaningless beyond seq_len, so no reset.
  always_ff @(posedge Clk) begin
    if (Rst && (state_reg == S_APPEND) && (seq_len < LEN_MAX)) begin
      seq_mem[IDX_W'(seq_len)] <= cand_sym;
    end
  end

  // Outputs are registered on the transition into a state, so they reflect
  // the current state: the pass/fail pulse and the score change are visible
  // together during the single PASS / FAIL cycle.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_reg  <= S_IDLE;
      seq_len    <= '0;
      entry_idx  <= '0;
      points     <= '0;
      to_cnt_reg <= '0;
      timer_en   <= 1'b0;
      disp_sym   <= BLANK;
      round_pass <= 1'b0;
      round_fail <= 1'b0;
    end else begin
      round_pass <= 1'b0;
      round_fail <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          timer_en <= 1'b0;
          disp_sym <= BLANK;
          if (start_in) begin
            state_reg <= S_APPEND;
          end
        end

        S_APPEND: begin
          // At full length the buffer is left as is and simply replayed.
          if (seq_len < LEN_MAX) begin
            seq_len <= seq_len + LEN_W'(1);
          end
          entry_idx <= '0;
          timer_en  <= 1'b1;
          state_reg <= S_SHOW;
        end

        S_SHOW: begin
          if (tick_1s) begin
            if (entry_idx < seq_len) begin
              disp_sym  <= {1'b0, cur_sym};
              entry_idx <= entry_idx + LEN_W'(1);
            end else begin
              disp_sym   <= BLANK;
              entry_idx  <= '0;
              to_cnt_reg <= '0;
              state_reg  <= S_WAIT_IN;
            end
          end
        end

        S_WAIT_IN: begin
          if (wait_miss) begin
            timer_en   <= 1'b0;
            round_fail <= 1'b1;
            if (points != '0) begin
              points <= points - PTS_W'(1);
            end
            if (STRICT != 0) begin
              seq_len <= '0;
            end
            state_reg <= S_FAIL;
          end else if (p_valid) begin
            entry_idx  <= entry_idx + LEN_W'(1);
            to_cnt_reg <= '0;
            if ((entry_idx + LEN_W'(1)) == seq_len) begin
              timer_en   <= 1'b0;
              round_pass <= 1'b1;
              if (points != PTS_MAX) begin
                points <= points + PTS_W'(1);
              end
              state_reg <= S_PASS;
            end
          end else if (tick_1s) begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
        end

        S_PASS, S_FAIL: begin
          timer_en  <= 1'b0;
          disp_sym  <= BLANK;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
